mul_share_arbiter: RTL
======================

// Module: mul_share_arbiter
// PURPOSE
//   Shares one 64x64 radix-2 Booth multiplier core between NUM_REQ requesters.
//   Round-robin grant; latches the winner's operands and sequences the core
//   (op_start pulse, wait op_done, capture result, op_clear pulse).
//   Returns a tagged 128-bit product, or an error response on timeout.
//   Sits between the requesting datapaths and the shared multiplier instance.
// PARAMETERS
//   NUM_REQ  4    number of requesters, 2..8
//   ID_W     2    requester index width, = clog2(NUM_REQ)
//   TIMEOUT  255  max cycles in WAIT before an error response; core nominal 130..194
// PORTS
//   clk          in   1            clock, rising edge
//   reset        in   1            asynchronous, active-high reset
//   req_valid    in   NUM_REQ      per-requester request; held until req_ack
//   req_a        in   NUM_REQ*64   multiplier operands, requester i at [64*i+63:64*i]
//   req_b        in   NUM_REQ*64   multiplicand operands, same packing
//   req_ack      out  NUM_REQ      one-hot, one-cycle acceptance pulse
//   flush        in   1            synchronous abort of the current operation
//   rsp_valid    out  1            one-cycle response pulse
//   rsp_id       out  ID_W         requester index of the response
//   rsp_result   out  128          signed product; 0 when rsp_err=1
//   rsp_err      out  1            response is a timeout error
//   busy         out  1            high in every state except IDLE
//   mul_a        out  64           to core multiplier; holds the latched operand
//   mul_b        out  64           to core multiplicand; holds the latched operand
//   mul_start    out  1            to core op_start
//   mul_clear    out  1            to core op_clear
//   mul_done     in   1            from core op_done; high exactly one cycle
//   mul_result   in   128          from core result; valid while mul_done=1
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; rr_ptr=0; timer=0; operand registers 0.
//   FSM states: IDLE, START, WAIT, CLEAR.
//   - IDLE: if any req_valid, winner is the first set index scanning rr_ptr,
//     rr_ptr+1, ... modulo NUM_REQ. Same edge: latch req_a/req_b slice into
//     mul_a/mul_b, latch id, pulse req_ack[winner], rr_ptr<=winner+1 mod NUM_REQ,
//     go to START. If no request, stay in IDLE.
//   - START: mul_start=1 for exactly this cycle; timer<=0; go to WAIT.
//   - WAIT: mul_start=0; timer increments each cycle.
//     * mul_done=1: next cycle rsp_valid=1, rsp_result=mul_result, rsp_id=id,
//       rsp_err=0; go to CLEAR.
//     * timer==TIMEOUT-1 with no done: next cycle rsp_valid=1, rsp_err=1,
//       rsp_result=0; go to CLEAR.
//   - CLEAR: mul_clear=1 for exactly this cycle; go to IDLE. A new grant can
//     occur in the cycle after CLEAR, never earlier.
//   - mul_a/mul_b hold constant from the grant edge until the exit from CLEAR.
//   - rsp_result/rsp_id/rsp_err hold their values after the pulse, until the
//     next response.
//   - flush=1 in START or WAIT: go to CLEAR, no response. flush in IDLE or
//     CLEAR: ignored. flush wins over a simultaneous mul_done.
//   - req_valid deasserted before its ack: request is dropped, no response.
//     A requester may re-raise req_valid in the cycle after its ack.
//   - mul_done outside WAIT is ignored.
//   - Reset mid-operation: immediate return to reset values. The core is reset
//     by the same system reset; no response is issued.
// TESTING
//   1 Single op: req0 a=3, b=-5 -> req_ack=0001 on the next edge; one mul_start
//     pulse; rsp_valid with id=0, result=-15 (128'hFFFF...FFF1), err=0; then one
//     mul_clear pulse.
//   2 All four requests held from reset -> grants in order 0,1,2,3, then 0 again
//     if still requesting; each rsp_id matches its grant order.
//   3 Fairness: rr_ptr=2; req1 and req3 both set -> req3 granted first,
//     then req1.
//   4 Extremes: a=b=64'h8000_0000_0000_0000 -> result 128'h4000..0 (2^126);
//     a=-1, b=-1 -> result 1.
//   5 Timeout with a stub core that never raises done and TIMEOUT=16 -> rsp_err=1
//     and result=0 exactly 17 cycles after the mul_start cycle; mul_clear pulses;
//     the next request is served.
//   6 Flush in WAIT cycle 10 -> no rsp_valid; mul_clear pulses; busy falls.
//     Reset asserted mid-WAIT -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// Round-robin front end for one shared 64x64 multiplier; grant-to-response is core latency + 3 cycles (timeout bounds WAIT).
// Requesters hold req_valid until their one-cycle req_ack; no new grant until the cycle after CLEAR.
module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*64-1:0] req_a,
    input  logic [NUM_REQ*64-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ack,
    input  logic                  flush,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [127:0]          rsp_result,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [63:0]           mul_a,
    output logic [63:0]           mul_b,
    output logic                  mul_start,
    output logic                  mul_clear,
    input  logic                  mul_done,
    input  logic [127:0]          mul_result
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CLEAR
    } state_t;

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  cur_id;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  win_nxt;
    logic             win_vld;
    logic [TMR_W-1:0] timer;
    logic [63:0]      op_a [NUM_REQ];
    logic [63:0]      op_b [NUM_REQ];
    int               idx;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_a[i] = req_a[64*i +: 64];
        assign op_b[i] = req_b[64*i +: 64];
    end

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_vld && req_valid[ID_W'(idx)]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
        win_nxt = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            cur_id     <= '0;
            timer      <= '0;
            req_ack    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_start  <= 1'b0;
            mul_clear  <= 1'b0;
        end else begin
            req_ack   <= '0;
            rsp_valid <= 1'b0;
            mul_start <= 1'b0;
            mul_clear <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        mul_a     <= op_a[win_id];
                        mul_b     <= op_b[win_id];
                        cur_id    <= win_id;
                        req_ack   <= NUM_REQ'(1) << win_id;
                        rr_ptr    <= win_nxt;
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    timer <= '0;
                    if (flush) begin
                        mul_clear <= 1'b1;
                        state     <= S_CLEAR;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    // Abort beats a coincident done; done beats the timeout.
                    if (flush) begin
                        mul_clear <= 1'b1;
                        state     <= S_CLEAR;
                    end else if (mul_done) begin
                        rsp_valid  <= 1'b1;
                        rsp_id     <= cur_id;
                        rsp_result <= mul_result;
                        rsp_err    <= 1'b0;
                        mul_clear  <= 1'b1;
                        state      <= S_CLEAR;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        rsp_valid  <= 1'b1;
                        rsp_id     <= cur_id;
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        mul_clear  <= 1'b1;
                        state      <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
